// File: rtl/wb_port_arbiter_pkg.sv
// Shared defines for the writeback port arbiter: PRF/ROB payload structs and default sizes.
// Imported by wb_port_arbiter and its rotate-priority picker.
package wb_port_arbiter_pkg;

   localparam int DEF_NUM_FU    = 4;
   localparam int DEF_NUM_WPORT = 2;
   localparam int PRF_ADDR_W    = 6;
   localparam int XLEN          = 32;
   localparam int ROB_ID_W      = 5;

   typedef struct packed {
      logic                  wen;
      logic [PRF_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       wdata;
   } PRFwInfo;

   typedef struct packed {
      logic                setFinish;
      logic [ROB_ID_W-1:0] robID;
   } FUROBInfo;

   // Pointer width that stays legal when there is only one requester.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority select of up to NUM_SEL requesters,
// scanning cyclically from i_ptr; the k-th hit in scan order lands in slot k.
module wb_port_arbiter_rr_picker
   import wb_port_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_FU,
   parameter  int NUM_SEL = DEF_NUM_WPORT,
   localparam int PTR_W   = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [NUM_SEL-1:0] o_sel_vld,
   output logic [PTR_W-1:0]   o_sel_idx [NUM_SEL],
   output logic               o_any,
   output logic [PTR_W-1:0]   o_last_idx
);

   always_comb begin
      int   cnt;
      int   idx;
      logic hit;
      // NOTE: every output gets a default before the scan, so no path leaves a latch behind.
      o_grant    = '0;
      o_sel_vld  = '0;
      o_any      = 1'b0;
      o_last_idx = '0;
      cnt        = 0;
      idx        = 0;
      hit        = 1'b0;
      for (int p = 0; p < NUM_SEL; p++) o_sel_idx[p] = '0;

      for (int off = 0; off < NUM_REQ; off++) begin
         idx = (int'(i_ptr) + off) % NUM_REQ;
         hit = 1'b0;
         for (int i = 0; i < NUM_REQ; i++)
            if (i == idx && i_req[i]) hit = 1'b1;
         if (hit && cnt < NUM_SEL) begin
            for (int i = 0; i < NUM_REQ; i++)
               if (i == idx) o_grant[i] = 1'b1;
            for (int p = 0; p < NUM_SEL; p++)
               if (p == cnt) begin
                  o_sel_vld[p] = 1'b1;
                  o_sel_idx[p] = PTR_W'(idx);
               end
            o_last_idx = PTR_W'(idx);
            o_any      = 1'b1;
            cnt        = cnt + 1;
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: round-robin maps up to NUM_WPORT finished FUs onto PRF write / ROB finish ports.
// Optional WB_ARB_PERF_EN adds a saturating count of cycles with more requesters than ports.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int NUM_FU    = DEF_NUM_FU,
   parameter int NUM_WPORT = DEF_NUM_WPORT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [NUM_FU-1:0] fu_valid,
   input  PRFwInfo           fu_wb    [NUM_FU],
   input  FUROBInfo          fu_fin   [NUM_FU],
   output logic [NUM_FU-1:0] fu_ready,
   output PRFwInfo           prf_wreq [NUM_WPORT],
   output FUROBInfo          rob_fin  [NUM_WPORT],
   output logic [31:0]       conflict_cnt
);

   localparam int PTR_W = ptr_width(NUM_FU);

   logic [PTR_W-1:0]     r_rr_ptr;
   PRFwInfo              r_prf_wreq [NUM_WPORT];
   FUROBInfo             r_rob_fin  [NUM_WPORT];

   logic [NUM_FU-1:0]    w_grant;
   logic [NUM_WPORT-1:0] w_sel_vld;
   logic [PTR_W-1:0]     w_sel_idx  [NUM_WPORT];
   logic                 w_any;
   logic [PTR_W-1:0]     w_last_idx;
   logic [PTR_W-1:0]     w_next_ptr;

   wb_port_arbiter_rr_picker #(
      .NUM_REQ (NUM_FU),
      .NUM_SEL (NUM_WPORT)
   ) u_rr_picker (
      .i_req      (fu_valid),
      .i_ptr      (r_rr_ptr),
      .o_grant    (w_grant),
      .o_sel_vld  (w_sel_vld),
      .o_sel_idx  (w_sel_idx),
      .o_any      (w_any),
      .o_last_idx (w_last_idx)
   );

   assign w_next_ptr = (w_last_idx == PTR_W'(NUM_FU - 1)) ? '0 : w_last_idx + 1'b1;

   // No handshake completes while the pipeline is being cleared.
   assign fu_ready = (rst || flush) ? '0 : w_grant;

   // NOTE: rst is synchronous, so it is simply the highest-priority branch of the clocked
   // update; all state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_rr_ptr <= '0;
         for (int p = 0; p < NUM_WPORT; p++) begin
            r_prf_wreq[p] <= '0;
            r_rob_fin[p]  <= '0;
         end
      end else begin
         if (w_any) r_rr_ptr <= w_next_ptr;
         for (int p = 0; p < NUM_WPORT; p++) begin
            if (w_sel_vld[p]) begin
               r_prf_wreq[p] <= fu_wb[w_sel_idx[p]];
               r_rob_fin[p]  <= fu_fin[w_sel_idx[p]];
            end else begin
               r_prf_wreq[p] <= '0;
               r_rob_fin[p]  <= '0;
            end
         end
      end
   end

   assign prf_wreq = r_prf_wreq;
   assign rob_fin  = r_rob_fin;

`ifdef WB_ARB_PERF_EN
   logic [31:0] r_conflict_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         r_conflict_cnt <= '0;
      else if (!flush && ($countones(fu_valid) > NUM_WPORT) && (r_conflict_cnt != '1))
         r_conflict_cnt <= r_conflict_cnt + 32'd1;
   end

   assign conflict_cnt = r_conflict_cnt;
`else
   assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (4 FUs, 2 ports); expected conflict count follows WB_ARB_PERF_EN.
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;

   localparam int NUM_FU    = 4;
   localparam int NUM_WPORT = 2;
`ifdef WB_ARB_PERF_EN
   localparam logic [31:0] EXP_CONFLICT = 32'd9;
`else
   localparam logic [31:0] EXP_CONFLICT = 32'd0;
`endif

   logic              clk;
   logic              rst;
   logic              flush;
   logic [NUM_FU-1:0] fu_valid;
   PRFwInfo           fu_wb    [NUM_FU];
   FUROBInfo          fu_fin   [NUM_FU];
   logic [NUM_FU-1:0] fu_ready;
   PRFwInfo           prf_wreq [NUM_WPORT];
   FUROBInfo          rob_fin  [NUM_WPORT];
   logic [31:0]       conflict_cnt;

   int vectors;
   int miscompares;

   wb_port_arbiter #(.NUM_FU(NUM_FU), .NUM_WPORT(NUM_WPORT)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .fu_valid     (fu_valid),
      .fu_wb        (fu_wb),
      .fu_fin       (fu_fin),
      .fu_ready     (fu_ready),
      .prf_wreq     (prf_wreq),
      .rob_fin      (rob_fin),
      .conflict_cnt (conflict_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   function automatic PRFwInfo exp_wb(input int i);
      return '{wen: 1'b1, rd: 6'(8 + i), wdata: 32'hC0DE_0000 + 32'(i)};
   endfunction

   function automatic FUROBInfo exp_fin(input int i);
      return '{setFinish: 1'b1, robID: 5'(i + 1)};
   endfunction

   task automatic load_default(input int i);
      fu_wb[i]  = exp_wb(i);
      fu_fin[i] = exp_fin(i);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      fu_valid = 4'b1111;
      tick();
      #1;
      vectors++;
      if (fu_ready !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ready: got %b want 0000", fu_ready);
      end
      tick();
      vectors++;
      if ({prf_wreq[0].wen, prf_wreq[1].wen, rob_fin[0].setFinish, rob_fin[1].setFinish} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_outputs: wen %b%b fin %b%b want all 0", prf_wreq[0].wen, prf_wreq[1].wen,
                  rob_fin[0].setFinish, rob_fin[1].setFinish);
      end
      vectors++;
      if (dut.r_rr_ptr !== 2'd0 || conflict_cnt !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_state: rr_ptr %0d cnt %0d want 0 0", dut.r_rr_ptr, conflict_cnt);
      end
      rst = 1'b0;
      fu_valid = 4'b0000;
      tick();
   endtask

   task automatic test_rotation;
      int          a;
      logic [3:0]  exp_ready;
      fu_valid = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         a         = (c == 1) ? 2 : 0;
         exp_ready = (c == 1) ? 4'b1100 : 4'b0011;
         #1;
         vectors++;
         if (fu_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL rot_ready c%0d: got %b want %b", c, fu_ready, exp_ready);
         end
         tick();
         vectors++;
         if ({prf_wreq[0], prf_wreq[1], rob_fin[0], rob_fin[1]} !==
             {exp_wb(a), exp_wb(a + 1), exp_fin(a), exp_fin(a + 1)}) begin
            miscompares++;
            $display("FAIL rot_ports c%0d: got %h %h %h %h want FU%0d,FU%0d", c, prf_wreq[0], prf_wreq[1],
                     rob_fin[0], rob_fin[1], a, a + 1);
         end
         vectors++;
         if (dut.r_rr_ptr !== 2'((a + 2) % 4)) begin
            miscompares++;
            $display("FAIL rot_ptr c%0d: got %0d want %0d", c, dut.r_rr_ptr, (a + 2) % 4);
         end
      end
      fu_valid = 4'b0000;
   endtask

   task automatic test_idle;
      #1;
      vectors++;
      if (fu_ready !== 4'b0000) begin
         miscompares++;
         $display("FAIL idle_ready: got %b want 0000", fu_ready);
      end
      tick();
      vectors++;
      if ({prf_wreq[0].wen, prf_wreq[1].wen, rob_fin[0].setFinish, rob_fin[1].setFinish} !== 4'b0000
          || dut.r_rr_ptr !== 2'd2) begin
         miscompares++;
         $display("FAIL idle_outputs: wen %b%b fin %b%b ptr %0d want 0000 ptr 2", prf_wreq[0].wen,
                  prf_wreq[1].wen, rob_fin[0].setFinish, rob_fin[1].setFinish, dut.r_rr_ptr);
      end
   endtask

   task automatic test_finish_only;
      fu_wb[2]  = '{wen: 1'b0, rd: 6'd33, wdata: 32'hDEAD_BEEF};
      fu_fin[2] = '{setFinish: 1'b1, robID: 5'd5};
      fu_valid  = 4'b0100;
      #1;
      vectors++;
      if (fu_ready !== 4'b0100) begin
         miscompares++;
         $display("FAIL fin_ready: got %b want 0100", fu_ready);
      end
      tick();
      vectors++;
      if (prf_wreq[0] !== PRFwInfo'{1'b0, 6'd33, 32'hDEAD_BEEF} || rob_fin[0] !== FUROBInfo'{1'b1, 5'd5}) begin
         miscompares++;
         $display("FAIL fin_port0: got %h %h want wen0 rd33 DEADBEEF, fin1 rob5", prf_wreq[0], rob_fin[0]);
      end
      vectors++;
      if ({prf_wreq[1].wen, rob_fin[1].setFinish} !== 2'b00 || dut.r_rr_ptr !== 2'd3) begin
         miscompares++;
         $display("FAIL fin_port1: wen %b fin %b ptr %0d want 0 0 ptr 3", prf_wreq[1].wen,
                  rob_fin[1].setFinish, dut.r_rr_ptr);
      end
      fu_valid = 4'b0000;
      load_default(2);
   endtask

   task automatic test_wrap;
      fu_valid = 4'b1001;
      #1;
      vectors++;
      if (fu_ready !== 4'b1001) begin
         miscompares++;
         $display("FAIL wrap_ready: got %b want 1001", fu_ready);
      end
      tick();
      vectors++;
      if ({prf_wreq[0], prf_wreq[1], rob_fin[0], rob_fin[1]} !== {exp_wb(3), exp_wb(0), exp_fin(3), exp_fin(0)}) begin
         miscompares++;
         $display("FAIL wrap_ports: got %h %h %h %h want FU3,FU0", prf_wreq[0], prf_wreq[1], rob_fin[0], rob_fin[1]);
      end
      vectors++;
      if (dut.r_rr_ptr !== 2'd1) begin
         miscompares++;
         $display("FAIL wrap_ptr: got %0d want 1", dut.r_rr_ptr);
      end
      fu_valid = 4'b0000;
   endtask

   task automatic test_flush;
      fu_valid = 4'b1111;
      flush    = 1'b1;
      #1;
      vectors++;
      if (fu_ready !== 4'b0000) begin
         miscompares++;
         $display("FAIL flush_ready: got %b want 0000", fu_ready);
      end
      tick();
      vectors++;
      if ({prf_wreq[0].wen, prf_wreq[1].wen, rob_fin[0].setFinish, rob_fin[1].setFinish} !== 4'b0000
          || dut.r_rr_ptr !== 2'd0) begin
         miscompares++;
         $display("FAIL flush_outputs: wen %b%b fin %b%b ptr %0d want 0000 ptr 0", prf_wreq[0].wen,
                  prf_wreq[1].wen, rob_fin[0].setFinish, rob_fin[1].setFinish, dut.r_rr_ptr);
      end
      flush    = 1'b0;
      fu_valid = 4'b0000;
   endtask

   task automatic test_perf;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         fu_valid = 4'b0111;
         flush    = (c == 4);
         tick();
      end
      fu_valid = 4'b0000;
      flush    = 1'b0;
      vectors++;
      if (conflict_cnt !== EXP_CONFLICT) begin
         miscompares++;
         $display("FAIL perf_count: got %0d want %0d", conflict_cnt, EXP_CONFLICT);
      end
   endtask

   task automatic test_reset_mid;
      fu_valid = 4'b1111;
      tick();
      tick();
      rst = 1'b1;
      #1;
      vectors++;
      if (fu_ready !== 4'b0000) begin
         miscompares++;
         $display("FAIL rstmid_ready: got %b want 0000", fu_ready);
      end
      tick();
      vectors++;
      if ({prf_wreq[0].wen, prf_wreq[1].wen, rob_fin[0].setFinish, rob_fin[1].setFinish} !== 4'b0000
          || dut.r_rr_ptr !== 2'd0 || conflict_cnt !== 32'd0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: wen %b%b fin %b%b ptr %0d cnt %0d want 0000 0 0", prf_wreq[0].wen,
                  prf_wreq[1].wen, rob_fin[0].setFinish, rob_fin[1].setFinish, dut.r_rr_ptr, conflict_cnt);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (fu_ready !== 4'b0011) begin
         miscompares++;
         $display("FAIL rstmid_represent: got %b want 0011", fu_ready);
      end
      tick();
      vectors++;
      if ({prf_wreq[0], prf_wreq[1]} !== {exp_wb(0), exp_wb(1)}) begin
         miscompares++;
         $display("FAIL rstmid_ports: got %h %h want FU0,FU1", prf_wreq[0], prf_wreq[1]);
      end
      fu_valid = 4'b0000;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      flush       = 1'b0;
      fu_valid    = '0;
      for (int i = 0; i < NUM_FU; i++) load_default(i);

      test_reset();
      test_rotation();
      test_idle();
      test_finish_only();
      test_wrap();
      test_flush();
      test_perf();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
